ring_output_scheduler: RTL

//  Per-output-port scheduler for the bidirectional ring router: arbitrates two input requesters (ring input + PE

---
 rtl/ring_output_scheduler_if.sv | 26 ++
 rtl/ring_output_scheduler.sv | 97 +++++++++
 2 files changed

// File: rtl/ring_output_scheduler_if.sv
// Requester/link bundle of one ring router output port: two requesters in,
// one link out, plus per-VC buffer status.
interface ring_output_scheduler_if #(
  parameter int PACKET_SIZE = 64
);
  logic                   req0;
  logic [PACKET_SIZE-1:0] data0;
  logic                   gnt0;
  logic                   req1;
  logic [PACKET_SIZE-1:0] data1;
  logic                   gnt1;
  logic                   so;
  logic                   ro;
  logic [PACKET_SIZE-1:0] dout;
  logic [1:0]             vc_full;

  modport master (
    output req0, data0, req1, data1, ro,
    input  gnt0, gnt1, so, dout, vc_full
  );

  modport slave (
    input  req0, data0, req1, data1, ro,
    output gnt0, gnt1, so, dout, vc_full
  );
endinterface

// File: rtl/ring_output_scheduler.sv
// Output-port scheduler: two requesters onto one link through two depth-1 VC
// buffers with rotating priority per VC. Optional counters: OUT_SCHED_CNT_EN.
module ring_output_scheduler #(
  parameter int PACKET_SIZE = 64,
  parameter int HOP_LSB     = 48,
  parameter int SHIFT_HOP   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    polarity,
  ring_output_scheduler_if.slave  bus
`ifdef OUT_SCHED_CNT_EN
  ,
  output logic [15:0]             cnt0,
  output logic [15:0]             cnt1,
  output logic [15:0]             stall_cnt
`endif
);

  logic [PACKET_SIZE-1:0] buf_p0 [2];
  logic [1:0]             full_p0;
  logic [1:0]             prio_p0;

  logic                   fill_vc;
  logic                   send_vc;
  logic                   buf_empty;
  logic                   gnt0;
  logic                   gnt1;
  logic                   send_ok;
  logic                   link_take;
  logic [PACKET_SIZE-1:0] wr_data;

  function automatic logic [PACKET_SIZE-1:0] hop_adjust(input logic [PACKET_SIZE-1:0] pkt);
    logic [PACKET_SIZE-1:0] r;
    r = pkt;
    if (SHIFT_HOP != 0) r[HOP_LSB +: 8] = {1'b0, pkt[HOP_LSB+1 +: 7]};
    return r;
  endfunction

`ifdef OUT_SCHED_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  // Fill and send VCs are always opposite, so a buffer is never written and read together.
  always_comb begin
    fill_vc   = ~polarity;
    send_vc   = polarity;
    buf_empty = reset & ~full_p0[fill_vc];
    gnt0      = buf_empty & bus.req0 & (~bus.req1 | prio_p0[fill_vc]);
    gnt1      = buf_empty & bus.req1 & (~bus.req0 | ~prio_p0[fill_vc]);
    wr_data   = hop_adjust(gnt1 ? bus.data1 : bus.data0);
    send_ok   = reset & full_p0[send_vc];
    link_take = send_ok & bus.ro;
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.so      = send_ok;
  assign bus.dout    = send_ok ? buf_p0[send_vc] : '0;
  assign bus.vc_full = reset ? full_p0 : 2'b00;

  // Stage p0: buffer occupancy and per-VC last winner
  always_ff @(posedge clk) begin
    if (!reset) begin
      full_p0 <= 2'b00;
      prio_p0 <= 2'b11;
    end else begin
      if (gnt0 | gnt1) begin
        full_p0[fill_vc] <= 1'b1;
        prio_p0[fill_vc] <= gnt1;
      end
      if (link_take) full_p0[send_vc] <= 1'b0;
    end
  end

  // Payload is only observable while its full flag is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (gnt0 | gnt1) buf_p0[fill_vc] <= wr_data;
  end

`ifdef OUT_SCHED_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt0      <= 16'd0;
      cnt1      <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (gnt0) cnt0 <= sat_inc(cnt0);
      if (gnt1) cnt1 <= sat_inc(cnt1);
      if (send_ok & ~bus.ro) stall_cnt <= sat_inc(stall_cnt);
    end
  end
`endif

endmodule
